output_port_drain: RTL and testbench
====================================

// Module: output_port_drain
// PURPOSE
//   Consumer end of the A09 output-port path. Captures every CPU output-port write (OUT_Ld strobe
//   plus the muxed output data) into a small FIFO and presents the values to a downstream device
//   (LED/UART shim, bench monitor) over a valid/ready handshake. Asserts Full so the control
//   matrix can stall output writes instead of losing data.
// PARAMETERS
//   DataWidth    8  width of one output word
//   DepthLog2    2  log2 of FIFO depth; Depth = 2**DepthLog2 entries (4 by default)
//   DropCntWidth 8  width of the dropped-write counter
// PORTS
//   Clk       in   1            single clock; all state updates on rising edge
//   Reset_N   in   1            asynchronous, active-low reset
//   Wr_En     in   1            write strobe, driven by CPU OUT_Ld
//   Wr_Data   in   DataWidth    word to enqueue (CPU output mux value)
//   Flush     in   1            synchronous clear of FIFO contents
//   Full      out  1            Level == Depth
//   Level     out  DepthLog2+1  number of stored entries, 0..Depth
//   M_Valid   out  1            head entry available (Level != 0)
//   M_Data    out  DataWidth    head entry, i.e. mem[rd_ptr]
//   M_Ready   in   1            downstream accepts head when M_Valid & M_Ready
//   Drop_Cnt  out  DropCntWidth count of writes lost while full (see CONFIGURATION)
// BEHAVIOUR
//   Reset (Reset_N=0, async): wr_ptr=rd_ptr=0, Level=0, all storage flops=0, so M_Valid=0,
//     M_Data=0, Full=0, Drop_Cnt=0. Outputs hold these values until the first edge after release.
//   push = Wr_En & ~Flush & (~Full | pop);   pop = M_Valid & M_Ready & ~Flush.
//   push: mem[wr_ptr] <= Wr_Data; wr_ptr <= wr_ptr+1 (mod Depth, natural wrap).
//   pop: rd_ptr <= rd_ptr+1 (mod Depth). Level <= Level + push - pop.
//   Latency: write in cycle N into an empty FIFO -> M_Valid=1, M_Data=Wr_Data in cycle N+1.
//     No same-cycle bypass.
//   M_Data/M_Valid are combinational from the registered state. While M_Valid & ~M_Ready,
//     M_Data stays stable.
//   Occupancy state (derived from Level): EMPTY (0) -> PARTIAL on push-only; PARTIAL -> FULL
//     when Level reaches Depth; FULL -> PARTIAL on pop-only; PARTIAL -> EMPTY when Level
//     reaches 0. Push+pop together leaves Level unchanged in any state.
//   Boundaries:
//     Full & Wr_En & ~pop: write discarded, storage unchanged, drop event.
//     Full & Wr_En & pop: both occur; Level stays Depth; no drop.
//     Empty & M_Ready: no effect (M_Valid=0); pointers do not move.
//     Pointer wrap Depth-1 -> 0 is seamless; FIFO order is preserved across the wrap.
//     Flush=1: next edge wr_ptr=rd_ptr=0, Level=0. Same-cycle write and pop are ignored;
//       an ignored write is not a drop. Storage contents are not cleared. Drop_Cnt is unaffected.
//     Reset_N low mid-transfer: immediate return to the reset state; the in-flight word is lost.
// CONFIGURATION
//   OUTPUT_PORT_DRAIN_DROPCNT_EN defined: Drop_Cnt increments once per drop event and saturates
//     at all-ones (never wraps). It is cleared only by Reset_N.
//   Not defined: counter logic is omitted; Drop_Cnt is tied to 0. Drops still discard silently.
// STRUCTURE
//   Shared constants include (alongside the sequence-control constants): default
//     OUT_DRAIN_DEPTH_LOG2 and OUT_DRAIN_DROPCNT_W, so cpu-level and bench instantiations agree.
//   One sub-module: drain_fifo_mem, a Depth x DataWidth flop array with async-low reset,
//     one write port and one combinational read port.
//   Pointers, Level, handshake and drop counter live in output_port_drain.
//   Depth must be a power of two; pointers are DepthLog2 bits wide.
// TESTING
//   1 Write 8'hA5 with M_Ready=0 -> next cycle M_Valid=1, M_Data=8'hA5, Level=1; it holds stable
//     for 5 cycles.
//   2 Write 8'h01..8'h04 back-to-back, M_Ready=0 -> Full=1, Level=4. Raise M_Ready ->
//     01,02,03,04 delivered in order, then M_Valid=0.
//   3 Full FIFO, Wr_En with M_Ready=0 -> data discarded, Level=4, Drop_Cnt=1 (macro on) or 0
//     (macro off).
//   4 Full FIFO, Wr_En=1 with 8'h55 and M_Ready=1 in the same cycle -> head popped, 8'h55
//     accepted, Level=4, no drop.
//   5 Stream 10 words with M_Ready=1 continuously -> pointers wrap twice, all 10 words
//     delivered in order.
//   6 Level=3, assert Flush together with Wr_En -> next cycle Level=0, M_Valid=0,
//     Drop_Cnt unchanged. Then pulse Reset_N low mid-stream -> outputs immediately return
//     to their reset values.

Source files
------------

// File: rtl/output_port_drain_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : output_port_drain_pkg
//  Purpose  : Shared constants and types for the A09 CPU sequencer and the
//             output-port drain FIFO, so CPU-level and bench instantiations
//             agree on widths and depths.
//  Revision : 1.0  initial release
// ============================================================================
package output_port_drain_pkg;

    // Microsequencer constants shared with the control matrix
    localparam int SEQ_UPC_W       = 8;
    localparam int SEQ_STEP_W      = 4;
    localparam int SEQ_RESET_UPC   = 0;

    // Output-port drain defaults
    localparam int OUT_DRAIN_DATA_W     = 8;
    localparam int OUT_DRAIN_DEPTH_LOG2 = 2;
    localparam int OUT_DRAIN_DROPCNT_W  = 8;

    // Occupancy classification of the drain FIFO
    typedef enum logic [1:0] {
        OCC_EMPTY   = 2'd0,
        OCC_PARTIAL = 2'd1,
        OCC_FULL    = 2'd2
    } occ_state_e;

    // Map a fill level onto the occupancy state
    function automatic occ_state_e occ_from_level(input int unsigned level,
                                                  input int unsigned depth);
        occ_state_e st;
        if (level == 0)
            st = OCC_EMPTY;
        else if (level >= depth)
            st = OCC_FULL;
        else
            st = OCC_PARTIAL;
        return st;
    endfunction

endpackage : output_port_drain_pkg
`default_nettype wire

// File: rtl/drain_fifo_mem.sv
`default_nettype none
// ============================================================================
//  Module   : drain_fifo_mem
//  Purpose  : Depth x DataWidth flop array for the output-port drain FIFO.
//             One synchronous write port, one combinational read port,
//             asynchronous active-low reset clears every entry.
//  Revision : 1.0  initial release
// ============================================================================
module drain_fifo_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    localparam int c_depth = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [c_depth];
    logic [DATA_WIDTH-1:0] mem_d [c_depth];

    for (genvar g = 0; g < c_depth; g++) begin : g_entry
        // Entry g takes the write data only when it is the addressed slot
        always_comb begin
            mem_d[g] = mem_q[g];
            if (i_wr_en && (i_wr_addr == ADDR_WIDTH'(g)))
                mem_d[g] = i_wr_data;
        end

        // Entry storage; cleared only by reset, never by a flush
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                mem_q[g] <= '0;
            else
                mem_q[g] <= mem_d[g];
        end
    end

    assign o_rd_data = mem_q[i_rd_addr];

endmodule : drain_fifo_mem
`default_nettype wire

// File: rtl/output_port_drain.sv
`default_nettype none
// ============================================================================
//  Module   : output_port_drain
//  Purpose  : Captures CPU output-port writes into a small FIFO and presents
//             them downstream over a valid/ready handshake. Full lets the
//             control matrix stall OUT writes instead of losing data.
//  Options  : OUTPUT_PORT_DRAIN_DROPCNT_EN - enables the saturating count of
//             writes discarded while full; otherwise Drop_Cnt is tied to 0.
//  Revision : 1.0  initial release
// ============================================================================
module output_port_drain
    import output_port_drain_pkg::*;
#(
    parameter int DataWidth    = OUT_DRAIN_DATA_W,
    parameter int DepthLog2    = OUT_DRAIN_DEPTH_LOG2,
    parameter int DropCntWidth = OUT_DRAIN_DROPCNT_W
) (
    input  logic                    Clk,
    input  logic                    Reset_N,
    input  logic                    Wr_En,
    input  logic [DataWidth-1:0]    Wr_Data,
    input  logic                    Flush,
    output logic                    Full,
    output logic [DepthLog2:0]      Level,
    output logic                    M_Valid,
    output logic [DataWidth-1:0]    M_Data,
    input  logic                    M_Ready,
    output logic [DropCntWidth-1:0] Drop_Cnt
);

    localparam int c_depth = 2 ** DepthLog2;

    logic [DepthLog2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DepthLog2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DepthLog2:0]   level_q,  level_d;
    occ_state_e           occ_q,    occ_d;

    logic w_full;
    logic w_valid;
    logic w_push;
    logic w_pop;

    // Full and valid come straight from the registered occupancy state
    assign w_full  = (occ_q == OCC_FULL);
    assign w_valid = (occ_q != OCC_EMPTY);

    // A pop frees a slot in the same cycle, so a write while full still
    // lands when the head is being taken; flush suppresses both sides
    assign w_pop  = w_valid & M_Ready & ~Flush;
    assign w_push = Wr_En & ~Flush & (~w_full | w_pop);

    // Next pointers, level and occupancy state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (Flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (w_push)
                wr_ptr_d = wr_ptr_q + DepthLog2'(1);
            if (w_pop)
                rd_ptr_d = rd_ptr_q + DepthLog2'(1);
            case ({w_push, w_pop})
                2'b10:   level_d = level_q + (DepthLog2 + 1)'(1);
                2'b01:   level_d = level_q - (DepthLog2 + 1)'(1);
                default: level_d = level_q;
            endcase
        end
        occ_d = occ_from_level(32'(level_d), c_depth);
    end

    // Pointer, level and occupancy registers
    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            occ_q    <= OCC_EMPTY;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            occ_q    <= occ_d;
        end
    end

    drain_fifo_mem #(
        .DATA_WIDTH (DataWidth),
        .ADDR_WIDTH (DepthLog2)
    ) u_mem (
        .clk        (Clk),
        .rst_n      (Reset_N),
        .i_wr_en    (w_push),
        .i_wr_addr  (wr_ptr_q),
        .i_wr_data  (Wr_Data),
        .i_rd_addr  (rd_ptr_q),
        .o_rd_data  (M_Data)
    );

    assign Full    = w_full;
    assign Level   = level_q;
    assign M_Valid = w_valid;

`ifdef OUTPUT_PORT_DRAIN_DROPCNT_EN
    logic [DropCntWidth-1:0] drop_cnt_q, drop_cnt_d;
    logic                    w_drop;

    // A drop is a real write refused for lack of room; flushed writes are not drops
    assign w_drop = Wr_En & ~Flush & w_full & ~w_pop;

    // Saturating increment so a long stall never wraps back to a small count
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (w_drop && (drop_cnt_q != {DropCntWidth{1'b1}}))
            drop_cnt_d = drop_cnt_q + DropCntWidth'(1);
    end

    // Drop counter register, cleared only by reset
    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N)
            drop_cnt_q <= '0;
        else
            drop_cnt_q <= drop_cnt_d;
    end

    assign Drop_Cnt = drop_cnt_q;
`else
    assign Drop_Cnt = '0;
`endif

endmodule : output_port_drain
`default_nettype wire

// File: tb/tb_output_port_drain.sv
`default_nettype none
// ============================================================================
//  Module   : tb_output_port_drain
//  Purpose  : Self-checking bench for output_port_drain. Stimulus pushes
//             expected words into a scoreboard queue; a monitor pops and
//             compares on every accepted handshake.
//  Revision : 1.0  initial release
// ============================================================================
module tb_output_port_drain;
    import output_port_drain_pkg::*;

`ifdef OUTPUT_PORT_DRAIN_DROPCNT_EN
    localparam int c_exp_drop = 1;
`else
    localparam int c_exp_drop = 0;
`endif

    logic        Clk = 1'b0;
    logic        Reset_N;
    logic        Wr_En;
    logic [7:0]  Wr_Data;
    logic        Flush;
    logic        Full;
    logic [2:0]  Level;
    logic        M_Valid;
    logic [7:0]  M_Data;
    logic        M_Ready;
    logic [7:0]  Drop_Cnt;

    int checks = 0;
    int errors = 0;
    int pops_seen = 0;
    logic [7:0] exp_q [$];

    output_port_drain dut (
        .Clk      (Clk),
        .Reset_N  (Reset_N),
        .Wr_En    (Wr_En),
        .Wr_Data  (Wr_Data),
        .Flush    (Flush),
        .Full     (Full),
        .Level    (Level),
        .M_Valid  (M_Valid),
        .M_Data   (M_Data),
        .M_Ready  (M_Ready),
        .Drop_Cnt (Drop_Cnt)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Scoreboard monitor: the handshake completes at the next rising edge
    always @(negedge Clk) begin
        if (Reset_N === 1'b1 && M_Valid === 1'b1 && M_Ready === 1'b1 && Flush === 1'b0) begin
            checks++;
            pops_seen++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_word: got %0h expected none", M_Data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (M_Data !== e) begin
                    errors++;
                    $display("FAIL word_order: got %0h expected %0h", M_Data, e);
                end
            end
        end
    end

    task automatic drain(input string name);
        M_Ready = 1'b1;
        for (int i = 0; i < 20 && M_Valid; i++) step();
        M_Ready = 1'b0;
        check({name, "_valid_low"}, 32'(M_Valid), 32'd0);
        check({name, "_sb_empty"},  32'(exp_q.size()), 32'd0);
        check({name, "_level0"},    32'(Level), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        Reset_N = 1'b0; Wr_En = 1'b0; Wr_Data = 8'h00; Flush = 1'b0; M_Ready = 1'b0;
        #12;
        check("rst_valid", 32'(M_Valid), 32'd0);
        check("rst_data",  32'(M_Data),  32'd0);
        check("rst_full",  32'(Full),    32'd0);
        check("rst_level", 32'(Level),   32'd0);
        check("rst_drop",  32'(Drop_Cnt), 32'd0);
        step();
        Reset_N = 1'b1;
        step();

        // 1: single write, head holds while not ready
        Wr_En = 1'b1; Wr_Data = 8'hA5; exp_q.push_back(8'hA5);
        step();
        Wr_En = 1'b0;
        check("t1_valid", 32'(M_Valid), 32'd1);
        check("t1_data",  32'(M_Data),  32'hA5);
        check("t1_level", 32'(Level),   32'd1);
        for (int i = 0; i < 5; i++) begin
            step();
            check("t1_hold", 32'({M_Valid, M_Data}), 32'h1A5);
        end
        drain("t1");

        // 2: fill to full, then drain in order
        for (int i = 1; i <= 4; i++) begin
            Wr_En = 1'b1; Wr_Data = 8'(i); exp_q.push_back(8'(i));
            step();
        end
        Wr_En = 1'b0;
        check("t2_full",  32'(Full),  32'd1);
        check("t2_level", 32'(Level), 32'd4);

        // 3: write while full and not ready is dropped
        Wr_En = 1'b1; Wr_Data = 8'hEE;
        step();
        Wr_En = 1'b0;
        check("t3_level", 32'(Level),    32'd4);
        check("t3_drop",  32'(Drop_Cnt), 32'(c_exp_drop));
        check("t3_head",  32'(M_Data),   32'h01);

        // 4: write while full with a simultaneous pop
        Wr_En = 1'b1; Wr_Data = 8'h55; M_Ready = 1'b1; exp_q.push_back(8'h55);
        step();
        Wr_En = 1'b0; M_Ready = 1'b0;
        check("t4_level", 32'(Level),    32'd4);
        check("t4_full",  32'(Full),     32'd1);
        check("t4_drop",  32'(Drop_Cnt), 32'(c_exp_drop));
        check("t4_head",  32'(M_Data),   32'h02);
        drain("t4");

        // 5: continuous stream across pointer wraps
        pops_seen = 0;
        M_Ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            Wr_En = 1'b1; Wr_Data = 8'h10 + 8'(i); exp_q.push_back(8'h10 + 8'(i));
            step();
        end
        Wr_En = 1'b0;
        drain("t5");
        check("t5_count", 32'(pops_seen), 32'd10);

        // 6: flush with a concurrent write, then reset mid-stream
        for (int i = 0; i < 3; i++) begin
            Wr_En = 1'b1; Wr_Data = 8'h30 + 8'(i);
            step();
        end
        check("t6_level3", 32'(Level), 32'd3);
        Wr_En = 1'b1; Wr_Data = 8'h77; Flush = 1'b1;
        step();
        Wr_En = 1'b0; Flush = 1'b0;
        check("t6_level0", 32'(Level),    32'd0);
        check("t6_valid0", 32'(M_Valid),  32'd0);
        check("t6_drop",   32'(Drop_Cnt), 32'(c_exp_drop));

        Wr_En = 1'b1; Wr_Data = 8'h91; step();
        Wr_Data = 8'h92; step();
        check("t6_level2", 32'(Level), 32'd2);
        Wr_Data = 8'h93;
        #2;
        Reset_N = 1'b0;
        #1;
        check("t6_rst_valid", 32'(M_Valid),  32'd0);
        check("t6_rst_data",  32'(M_Data),   32'd0);
        check("t6_rst_level", 32'(Level),    32'd0);
        check("t6_rst_full",  32'(Full),     32'd0);
        check("t6_rst_drop",  32'(Drop_Cnt), 32'd0);
        Wr_En = 1'b0;
        step();
        Reset_N = 1'b1;
        step();
        check("t6_post_valid", 32'(M_Valid), 32'd0);
        check("t6_sb_empty",   32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_output_port_drain
`default_nettype wire
